pwm_feeder: RTL and testbench

- Upstream stage of the PWM output path in the pedal datapath.
- Accepts signed two's-complement audio samples from the effects chain through a valid/ready handshake and buffers them in a small FIFO.
- Converts each sample to an unsigned duty value scaled to `0..max`.
- Presents exactly one `data_out`/`load` pair per PWM period, with the period counter kept in lock-step with the PWM stage's own 0..max counter.

---
 rtl/pwm_pkg.sv | 26 ++
 rtl/sync_fifo.sv | 54 +++++
 rtl/pwm_feeder.sv | 94 +++++++++
 tb/tb_pwm_feeder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared PWM definitions, imported by pwm_feeder and by the PWM stage.
//   PWM_WIDTH  : default sample/duty width
//   duty_t     : duty value type at the default width
//   to_offset  : signed two's-complement sample -> offset binary
//   scale_duty : offset-binary value -> duty in 0..max
// The helpers take the width as an argument, so any WIDTH up to 31 works.
package pwm_pkg;
  localparam int PWM_WIDTH = 10;

  typedef logic [PWM_WIDTH-1:0] duty_t;

  // Flip the sign bit: -2^(w-1)..2^(w-1)-1 maps onto 0..2^w-1.
  // s must be zero-extended from w bits by the caller.
  function automatic logic [31:0] to_offset(input logic [31:0] s, input int w);
    return s ^ (32'd1 << (w - 1));
  endfunction

  // (u * (max+1)) >> w. u < 2^w, so the result never exceeds max.
  function automatic logic [31:0] scale_duty(input logic [31:0] u,
                                             input logic [31:0] mx,
                                             input int w);
    logic [63:0] p;
    p = 64'(u) * (64'(mx) + 64'd1);
    return 32'(p >> w);
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO, registered occupancy.
//   clk, rst          : clock, async active-high reset (empties the FIFO)
//   i_push, i_din     : write request / data (ignored when full, even with a pop)
//   i_pop, o_dout     : read request / head word (ignored when empty)
//   o_full, o_empty   : derived from the registered level
//   o_level           : occupancy, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_din,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [AW:0]      r_level;
  logic             w_do_push, w_do_pop;

  assign o_full    = (r_level == (AW+1)'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_dout    = r_mem[r_rptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end
endmodule

// File: rtl/pwm_feeder.sv
// Feeds one duty value per PWM period to the PWM stage.
//   clk, rst                 : clock, async active-high reset
//   sample_in/valid/ready    : signed sample input handshake into the FIFO
//   max                      : PWM full-scale, shared with the PWM stage
//   underrun_clr             : clears the sticky underrun flag
//   data_out, load           : duty value and its once-per-period load pulse
//   underrun                 : set when a period boundary finds the FIFO empty
//   level                    : FIFO occupancy
// Build option PWM_FEEDER_HOLD_EN: on underrun hold the last duty value
// instead of outputting midscale.
module pwm_feeder
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       sample_in,
  input  logic                   sample_valid,
  output logic                   sample_ready,
  input  logic [WIDTH-1:0]       max,
  input  logic                   underrun_clr,
  output logic [WIDTH-1:0]       data_out,
  output logic                   load,
  output logic                   underrun,
  output logic [$clog2(DEPTH):0] level
);
  logic [WIDTH-1:0] r_pcount, r_data;
  logic             r_load, r_under, r_rdy;
  logic [WIDTH-1:0] w_head, w_u, w_scaled, w_mid;
  logic [WIDTH:0]   w_maxp1;
  logic             w_full, w_empty, w_bnd, w_push, w_pop;

  // r_rdy keeps sample_ready low through reset and goes high on the first
  // edge after release.
  assign sample_ready = r_rdy && !w_full;
  assign w_push       = sample_valid && sample_ready;
  // >= lets a lowered max take effect on the very next edge.
  assign w_bnd        = (r_pcount >= max);
  assign w_pop        = w_bnd && !w_empty;

  assign w_u      = WIDTH'(to_offset(32'(w_head), WIDTH));
  assign w_scaled = WIDTH'(scale_duty(32'(w_u), 32'(max), WIDTH));
  assign w_maxp1  = {1'b0, max} + (WIDTH+1)'(1);
  assign w_mid    = w_maxp1[WIDTH:1];

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   (sample_in),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pcount <= '0;
      r_load   <= 1'b0;
      r_data   <= '0;
      r_under  <= 1'b0;
      r_rdy    <= 1'b0;
    end else begin
      r_rdy <= 1'b1;
      if (w_bnd) begin
        r_pcount <= '0;
        r_load   <= 1'b1;
        if (!w_empty) begin
          r_data <= w_scaled;
        end else begin
`ifdef PWM_FEEDER_HOLD_EN
          r_data <= r_data;
`else
          r_data <= w_mid;
`endif
        end
      end else begin
        r_pcount <= r_pcount + WIDTH'(1);
        r_load   <= 1'b0;
      end
      // Set has priority over clear.
      if (w_bnd && w_empty)  r_under <= 1'b1;
      else if (underrun_clr) r_under <= 1'b0;
    end
  end

  assign data_out = r_data;
  assign load     = r_load;
  assign underrun = r_under;
endmodule

// File: tb/tb_pwm_feeder.sv
module tb_pwm_feeder;
  localparam int W = 10;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] sample_in = '0;
  logic         sample_valid = 1'b0;
  logic         sample_ready;
  logic [W-1:0] max_i = 10'd1023;
  logic         underrun_clr = 1'b0;
  logic [W-1:0] data_out;
  logic         load;
  logic         underrun;
  logic [2:0]   level;

  int total = 0;
  int bad   = 0;

  pwm_feeder #(.WIDTH(W), .DEPTH(D)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .max          (max_i),
    .underrun_clr (underrun_clr),
    .data_out     (data_out),
    .load         (load),
    .underrun     (underrun),
    .level        (level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] mx;
    logic [W-1:0] smp;
    logic [W-1:0] exp;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  // Release lands on a negedge, so the next posedge is edge 1.
  task automatic do_reset();
    rst = 1'b1;
    sample_valid = 1'b0;
    underrun_clr = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Counts negedges until load is seen; -1 on timeout.
  task automatic wait_load(input int budget, output int n);
    n = 0;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if (load) return;
    end
    n = -1;
  endtask

  function automatic logic [W-1:0] under_val(input logic [W-1:0] mx, input logic [W-1:0] last);
`ifdef PWM_FEEDER_HOLD_EN
    return last;
`else
    return W'((int'(mx) + 1) >> 1);
`endif
  endfunction

  initial begin
    int n;
    tbl[0] = '{10'd1023, 10'h000, 10'd512};
    tbl[1] = '{10'd1023, 10'h200, 10'd0};
    tbl[2] = '{10'd1023, 10'h1FF, 10'd1023};
    tbl[3] = '{10'd99,   10'h000, 10'd50};
    tbl[4] = '{10'd99,   10'h200, 10'd0};
    tbl[5] = '{10'd99,   10'h1FF, 10'd99};
    tbl[6] = '{10'd10,   10'h000, 10'd5};
    tbl[7] = '{10'd10,   10'h100, 10'd8};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_level", 32'(level), 0);
    chk("rst_load", 32'(load), 0);
    chk("rst_data", 32'(data_out), 0);
    chk("rst_under", 32'(underrun), 0);
    chk("rst_ready", 32'(sample_ready), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rel", 32'(sample_ready), 1);

    // Table: one sample, first load timing/value, then an underrun load.
    for (int i = 0; i < 8; i++) begin
      max_i = tbl[i].mx;
      do_reset();
      @(negedge clk);
      sample_in = tbl[i].smp;
      sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      wait_load(2000, n);
      chk($sformatf("t%0d_first_load_at", i), 32'(n + 2), 32'(int'(tbl[i].mx) + 1));
      chk($sformatf("t%0d_data", i), 32'(data_out), 32'(tbl[i].exp));
      chk($sformatf("t%0d_under0", i), 32'(underrun), 0);
      wait_load(2000, n);
      chk($sformatf("t%0d_period", i), 32'(n), 32'(int'(tbl[i].mx) + 1));
      chk($sformatf("t%0d_under_data", i), 32'(data_out), 32'(under_val(tbl[i].mx, tbl[i].exp)));
      chk($sformatf("t%0d_under1", i), 32'(underrun), 1);
    end

    // Three consecutive samples at max=1023
    max_i = 10'd1023;
    do_reset();
    @(negedge clk);
    sample_valid = 1'b1;
    sample_in = 10'h000; @(negedge clk);
    sample_in = 10'h200; @(negedge clk);
    sample_in = 10'h1FF; @(negedge clk);
    sample_valid = 1'b0;
    chk("seq_level3", 32'(level), 3);
    wait_load(2000, n);
    chk("seq_first_at", 32'(n + 4), 1024);
    chk("seq_d0", 32'(data_out), 512);
    wait_load(2000, n);
    chk("seq_gap1", 32'(n), 1024);
    chk("seq_d1", 32'(data_out), 0);
    wait_load(2000, n);
    chk("seq_gap2", 32'(n), 1024);
    chk("seq_d2", 32'(data_out), 1023);
    chk("seq_level0", 32'(level), 0);
    chk("seq_no_under", 32'(underrun), 0);

    // Five pushes into a depth-4 FIFO, no pops
    do_reset();
    @(negedge clk);
    sample_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sample_in = W'(i);
      @(negedge clk);
    end
    sample_valid = 1'b0;
    chk("full_ready", 32'(sample_ready), 0);
    chk("full_level", 32'(level), 4);

    // Underrun with no pushes, clear, then clear colliding with a set
    max_i = 10'd99;
    do_reset();
    wait_load(500, n);
    chk("ur_first_at", 32'(n), 100);
    chk("ur_flag", 32'(underrun), 1);
    chk("ur_data", 32'(data_out), 32'(under_val(10'd99, 10'd0)));
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    chk("ur_cleared", 32'(underrun), 0);
    repeat (98) @(negedge clk);
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    chk("ur_clr_bnd_load", 32'(load), 1);
    chk("ur_set_wins", 32'(underrun), 1);

    // max = 0: every edge is a boundary, one pop per cycle
    max_i = 10'd0;
    do_reset();
    @(negedge clk);
    chk("m0_load_a", 32'(load), 1);
    sample_in = 10'h1FF;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    chk("m0_load_b", 32'(load), 1);
    chk("m0_stored", 32'(level), 1);
    @(negedge clk);
    chk("m0_load_c", 32'(load), 1);
    chk("m0_popped", 32'(level), 0);

    // max lowered 1023 -> 10 at pcount=500
    max_i = 10'd1023;
    do_reset();
    repeat (500) @(negedge clk);
    chk("mc_no_load_yet", 32'(load), 0);
    max_i = 10'd10;
    @(negedge clk);
    chk("mc_wrap", 32'(load), 1);
    wait_load(100, n);
    chk("mc_gap1", 32'(n), 11);
    wait_load(100, n);
    chk("mc_gap2", 32'(n), 11);

    // Reset mid-operation with 3 words queued
    max_i = 10'd1023;
    do_reset();
    @(negedge clk);
    sample_valid = 1'b1;
    sample_in = 10'h1FF; @(negedge clk);
    sample_in = 10'h000; @(negedge clk);
    sample_in = 10'h000; @(negedge clk);
    sample_in = 10'h000; @(negedge clk);
    sample_valid = 1'b0;
    wait_load(2000, n);
    chk("mr_pre_data", 32'(data_out), 1023);
    chk("mr_pre_level", 32'(level), 3);
    #2 rst = 1'b1;
    #1;
    chk("mr_level", 32'(level), 0);
    chk("mr_load", 32'(load), 0);
    chk("mr_data", 32'(data_out), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_load(2000, n);
    chk("mr_first_at", 32'(n), 1024);
    chk("mr_under_data", 32'(data_out), 32'(under_val(10'd1023, 10'd0)));
    chk("mr_under_flag", 32'(underrun), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
